// File: rtl/sys_bridge_n.sv
// CPU-to-peripheral bridge: decodes 16-byte device windows in one page, muxes read data,
// synchronises device interrupts (level or edge-latched) and flags unmapped accesses.
module sys_bridge_n #(
    parameter int unsigned     NDEV      = 2,
    parameter logic [23:0]     BASE      = 24'h00007F,
    parameter logic [NDEV-1:0] EDGE_MASK = {NDEV{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:2]          PrAddr,
    input  logic                 PrWe,
    input  logic                 PrRe,
    input  logic [31:0]          PrWD,
    output logic [31:0]          PrRD,
    input  logic [NDEV*32-1:0]   DEV_RD,
    output logic [3:2]           DEV_Addr,
    output logic [NDEV-1:0]      DEV_We,
    input  logic [NDEV-1:0]      IRQ,
    output logic [5:0]           HWInt
);

    localparam logic [3:0] WinRegs = 4'hF;
    localparam logic [3:0] NDevW   = 4'(NDEV);

    logic            page_hit;
    logic [3:0]      win;
    logic [1:0]      off;
    logic [NDEV-1:0] dev_hit;
    logic            ipend_sel;
    logic            err_sel;
    logic            access;
    logic            bad_win;
    logic            bad_reg;

    logic [NDEV-1:0] s1_q, s1_d;
    logic [NDEV-1:0] s2_q, s2_d;
    logic [NDEV-1:0] s3_q, s3_d;
    logic [NDEV-1:0] pend_q, pend_d;
    logic            err_q, err_d;
    logic [NDEV-1:0] rise;
    logic [NDEV-1:0] pend_clr;
    logic            err_set;
    logic            err_clr;

    assign page_hit  = (PrAddr[31:8] == BASE);
    assign win       = PrAddr[7:4];
    assign off       = PrAddr[3:2];
    assign DEV_Addr  = PrAddr[3:2];
    assign access    = PrWe | PrRe;
    assign ipend_sel = page_hit && (win == WinRegs) && (off == 2'd0);
    assign err_sel   = page_hit && (win == WinRegs) && (off == 2'd1);
    assign bad_win   = page_hit && (win >= NDevW) && (win != WinRegs);
    assign bad_reg   = page_hit && (win == WinRegs) && off[1];

    for (genvar i = 0; i < int'(NDEV); i++) begin : g_dev
        assign dev_hit[i] = page_hit && (win == 4'(i));
    end

    assign DEV_We = dev_hit & {NDEV{PrWe}};

    always_comb begin
        s1_d     = IRQ;
        s2_d     = s1_q;
        s3_d     = s2_q;
        // Only edge channels ever latch; level channels keep pend at 0.
        rise     = s2_q & ~s3_q & EDGE_MASK;
        pend_clr = (PrWe && ipend_sel) ? PrWD[NDEV-1:0] : '0;
        pend_d   = (pend_q & ~pend_clr) | rise;
        err_set  = access && (bad_win || bad_reg);
        err_clr  = PrWe && err_sel && PrWD[0];
        err_d    = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_hwint
        if (i < int'(NDEV)) begin : g_used
            assign HWInt[i] = EDGE_MASK[i] ? pend_q[i] : s2_q[i];
        end else begin : g_tied
            assign HWInt[i] = 1'b0;
        end
    end

    always_comb begin
        PrRD = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (dev_hit[i]) begin
                PrRD = DEV_RD[32*i +: 32];
            end
        end
        if (ipend_sel) begin
            PrRD = {26'b0, HWInt};
        end
        if (err_sel) begin
            PrRD = {31'b0, err_q};
        end
    end

    // Upper write-data bits only matter to devices, which take data directly from the CPU.
    logic unused_wd;
    assign unused_wd = ^PrWD[31:NDEV];

endmodule

// File: tb/tb_sys_bridge_n.sv
// Directed bench for sys_bridge_n (4 devices, channel 1 edge-latched) with an
// IRQ-history model checked every cycle plus literal spot checks.
module tb_sys_bridge_n;

    localparam logic [3:0] EM = 4'b0010;
    localparam logic [127:0] DRD = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    logic         clk;
    logic         rst_n;
    logic [31:2]  PrAddr;
    logic         PrWe;
    logic         PrRe;
    logic [31:0]  PrWD;
    logic [31:0]  PrRD;
    logic [127:0] DEV_RD;
    logic [3:2]   DEV_Addr;
    logic [3:0]   DEV_We;
    logic [3:0]   IRQ;
    logic [5:0]   HWInt;

    int vectors = 0;
    int errors  = 0;

    sys_bridge_n #(
        .NDEV      (4),
        .BASE      (24'h00007F),
        .EDGE_MASK (EM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PrAddr   (PrAddr),
        .PrWe     (PrWe),
        .PrRe     (PrRe),
        .PrWD     (PrWD),
        .PrRD     (PrRD),
        .DEV_RD   (DEV_RD),
        .DEV_Addr (DEV_Addr),
        .DEV_We   (DEV_We),
        .IRQ      (IRQ),
        .HWInt    (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: IRQ samples taken at each clock edge since reset, newest first.
    logic [3:0] hist[$];
    logic [3:0] m_pend;
    logic       m_err;

    function automatic logic [3:0] hget(input int k);
        return (k < hist.size()) ? hist[k] : 4'b0;
    endfunction

    function automatic bit in_page(input logic [31:2] a);
        logic [31:0] b;
        b = {a, 2'b00};
        return b[31:8] == 24'h00007F;
    endfunction

    function automatic int win_of(input logic [31:2] a);
        logic [31:0] b;
        b = {a, 2'b00};
        return int'(b[7:0]) / 16;
    endfunction

    function automatic int off_of(input logic [31:2] a);
        logic [31:0] b;
        b = {a, 2'b00};
        return (int'(b[7:0]) % 16) / 4;
    endfunction

    function automatic logic [5:0] exp_hw();
        // Level channel follows the sample from one edge earlier than the newest.
        return {2'b00, (m_pend & EM) | (hget(1) & ~EM)};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:2] a);
        int w;
        int o;
        if (!in_page(a)) return 32'h0;
        w = win_of(a);
        o = off_of(a);
        if (w < 4) return DRD[w*32 +: 32];
        if (w == 15 && o == 0) return {26'b0, exp_hw()};
        if (w == 15 && o == 1) return {31'b0, m_err};
        return 32'h0;
    endfunction

    function automatic logic [3:0] exp_we(input logic [31:2] a, input logic we);
        if (!we || !in_page(a) || win_of(a) >= 4) return 4'b0;
        return 4'b0001 << win_of(a);
    endfunction

    function automatic bit err_hit(input logic [31:2] a, input logic we, input logic re);
        int w;
        w = win_of(a);
        if (!(we || re) || !in_page(a)) return 1'b0;
        return (w >= 4 && w != 15) || (w == 15 && off_of(a) >= 2);
    endfunction

    function automatic logic [3:0] pend_clear(input logic [31:2] a, input logic we,
                                              input logic [31:0] wd);
        if (we && in_page(a) && win_of(a) == 15 && off_of(a) == 0) return wd[3:0];
        return 4'b0;
    endfunction

    function automatic bit err_clear(input logic [31:2] a, input logic we, input logic [31:0] wd);
        return we && in_page(a) && win_of(a) == 15 && off_of(a) == 1 && wd[0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_pend <= 4'b0;
            m_err  <= 1'b0;
        end else begin
            // A rise is seen once a 1 reaches the synchronised stage while the prior one was 0.
            m_pend <= (m_pend & ~pend_clear(PrAddr, PrWe, PrWD)) | (hget(1) & ~hget(2) & EM);
            m_err  <= (m_err & ~err_clear(PrAddr, PrWe, PrWD)) | err_hit(PrAddr, PrWe, PrRe);
            hist.push_front(IRQ);
            if (hist.size() > 4) hist.delete(4);
        end
    end

    always @(negedge clk) begin
        check("HWInt", {26'b0, HWInt}, {26'b0, exp_hw()});
        check("PrRD", PrRD, exp_rd(PrAddr));
        check("DEV_We", {28'b0, DEV_We}, {28'b0, exp_we(PrAddr, PrWe)});
        check("DEV_Addr", {30'b0, DEV_Addr}, {30'b0, PrAddr[3:2]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [31:0] b, input logic we, input logic re, input logic [31:0] wd);
        PrAddr = b[31:2];
        PrWe   = we;
        PrRe   = re;
        PrWD   = wd;
    endtask

    task automatic idle();
        acc(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        IRQ    = 4'b0;
        DEV_RD = DRD;
        idle();
        #2;
        check("rst_hwint", {26'b0, HWInt}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        acc(32'h00007F24, 1'b1, 1'b0, 32'h0);
        #1;
        check("wr_dev_we", {28'b0, DEV_We}, 32'h4);
        check("wr_dev_addr", {30'b0, DEV_Addr}, 32'h1);
        tick();
        acc(32'h00007F30, 1'b0, 1'b1, 32'h0);
        #1 check("rd_dev3", PrRD, 32'hCAFE0003);
        tick();
        acc(32'h00007F50, 1'b0, 1'b1, 32'h0);
        #1;
        check("unmapped_rd", PrRD, 32'h0);
        check("unmapped_we", {28'b0, DEV_We}, 32'h0);
        tick();
        acc(32'h00007FF4, 1'b0, 1'b0, 32'h0);
        #1 check("err_set", PrRD, 32'h1);
        tick();
        acc(32'h00007FF4, 1'b1, 1'b0, 32'h1);
        tick();
        acc(32'h00007FF4, 1'b0, 1'b0, 32'h0);
        #1 check("err_clr", PrRD, 32'h0);
        tick();
        acc(32'h00007FF8, 1'b1, 1'b0, 32'h0);
        #1 check("reg_off2_we", {28'b0, DEV_We}, 32'h0);
        tick();
        acc(32'h00007FF4, 1'b0, 1'b1, 32'h0);
        #1 check("err_off2", PrRD, 32'h1);
        tick();
        acc(32'h00007FF4, 1'b1, 1'b0, 32'hFFFF_FFFE);
        tick();
        acc(32'h00007FF4, 1'b0, 1'b0, 32'h0);
        #1 check("err_noclr", PrRD, 32'h1);
        acc(32'h00007FF4, 1'b1, 1'b0, 32'h1);
        tick();
        acc(32'h00001050, 1'b1, 1'b1, 32'h0);
        tick();
        acc(32'h00007FF4, 1'b0, 1'b0, 32'h0);
        #1 check("err_outside", PrRD, 32'h0);
        idle();
        tick();

        // Level channel 0: two-edge latency both ways, immune to IPEND writes.
        IRQ[0] = 1'b1;
        tick();
        check("lvl_k", {31'b0, HWInt[0]}, 32'h0);
        tick();
        check("lvl_k1", {31'b0, HWInt[0]}, 32'h1);
        acc(32'h00007FF0, 1'b1, 1'b0, 32'h1);
        tick();
        check("lvl_noclr", {31'b0, HWInt[0]}, 32'h1);
        idle();
        repeat (3) tick();
        IRQ[0] = 1'b0;
        tick();
        check("lvl_fall_k", {31'b0, HWInt[0]}, 32'h1);
        tick();
        check("lvl_fall_k1", {31'b0, HWInt[0]}, 32'h0);

        // Edge channel 1: 3-cycle pulse latches until cleared.
        IRQ[1] = 1'b1;
        tick();
        check("edge_k", {31'b0, HWInt[1]}, 32'h0);
        tick();
        check("edge_k1", {31'b0, HWInt[1]}, 32'h0);
        tick();
        check("edge_set", {31'b0, HWInt[1]}, 32'h1);
        IRQ[1] = 1'b0;
        repeat (4) tick();
        check("edge_hold", {31'b0, HWInt[1]}, 32'h1);
        acc(32'h00007FF0, 1'b0, 1'b0, 32'h0);
        #1 check("ipend_rd", PrRD, 32'h2);
        acc(32'h00007FF0, 1'b1, 1'b0, 32'h2);
        tick();
        check("edge_clr", {31'b0, HWInt[1]}, 32'h0);
        idle();

        // New rise lands on the same edge as the clear: set wins.
        IRQ[1] = 1'b1;
        tick();
        tick();
        acc(32'h00007FF0, 1'b1, 1'b0, 32'h2);
        tick();
        check("set_wins", {31'b0, HWInt[1]}, 32'h1);
        idle();
        tick();
        acc(32'h00007FF0, 1'b1, 1'b0, 32'h2);
        tick();
        check("clr_held_irq", {31'b0, HWInt[1]}, 32'h0);
        idle();
        IRQ[1] = 1'b0;
        repeat (3) tick();

        // Async reset mid-cycle with pend and err set, IRQ held through release.
        acc(32'h00007F50, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        IRQ[1] = 1'b1;
        repeat (3) tick();
        check("pre_rst_pend", {31'b0, HWInt[1]}, 32'h1);
        acc(32'h00007FF4, 1'b0, 1'b0, 32'h0);
        #1 check("pre_rst_err", PrRD, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_hw", {26'b0, HWInt}, 32'h0);
        check("rst_async_err", PrRD, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rel_e1", {31'b0, HWInt[1]}, 32'h0);
        tick();
        check("rel_e2", {31'b0, HWInt[1]}, 32'h0);
        tick();
        check("rel_e3", {31'b0, HWInt[1]}, 32'h1);
        IRQ = 4'b0;
        idle();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised system bridge between the CPU data port and up to six memory-mapped peripherals. It decodes CPU addresses into per-device 16-byte windows and steers write enables. It returns read data from the selected device or from its own status registers. It synchronises device interrupt lines into `HWInt`, with a per-channel choice of level or edge-latched interrupts. Unmapped accesses are flagged in a sticky error register.

## Interface
- `NDEV`, default 2, number of devices (1..6); window i spans byte address {BASE,8'h00}+16*i .. +16*i+15
- `BASE`, default 24'h00007F, `PrAddr[31:8]` page shared by all devices and the bridge registers
- `EDGE_MASK`, default {NDEV{1'b0}}, bit i = 1 makes IRQ channel i edge-latched; 0 makes it level
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `PrAddr`  in  [31:2]  CPU word address
- `PrWe`  in  1  CPU write strobe, one cycle per write
- `PrRe`  in  1  CPU read strobe; used only for error detection
- `PrWD`  in  32  CPU write data; consumed only by bridge registers
- `PrRD`  out  32  read data to CPU (combinational)
- `DEV_RD`  in  NDEV*32  device read data; device i occupies bits [32i+31:32i]
- `DEV_Addr`  out  [3:2]  word offset within the window, = `PrAddr[3:2]`
- `DEV_We`  out  NDEV  per-device write enable
- `IRQ`  in  NDEV  asynchronous device interrupt requests, active high
- `HWInt`  out  6  CPU hardware interrupt vector; bits ≥ NDEV tied to 0

## Operation
- page_hit = (`PrAddr[31:8]` == BASE); win = `PrAddr[7:4]`
- dev_hit[i] = page_hit & (win == i), for i < NDEV; `DEV_We[i]` = `PrWe` & dev_hit[i]
- Bridge registers (win == 4'hF, page_hit):
  - IPEND at offset 0 (0x..F0)
  - ERR at offset 1 (0x..F4)
  - offsets 2–3 read 0 and ignore writes
- Read mux:
  - dev_hit[i] → `DEV_RD` slice i
  - IPEND → {26'b0, `HWInt`}
  - ERR → {31'b0, err}
  - anything else → 32'h0 (no default device)
- IRQ path per channel: two-flop synchroniser s1→s2, plus history flop s3 <= s2
  - Level channel: `HWInt[i]` = s2[i]
  - Edge channel: pend[i] is set when s2 & ~s3 and cleared by a write to IPEND with `PrWD[i]`=1; `HWInt[i]` = pend[i]
  - Set and clear in the same cycle: set wins, pend stays 1
  - Writes to IPEND do not affect level channels
- Error register:
  - err is set when (`PrWe` | `PrRe`) & page_hit & win ≥ NDEV & win != 4'hF
  - err is set when (`PrWe` | `PrRe`) & page_hit & win == 4'hF & offset ≥ 2
  - Cleared by a write to ERR with `PrWD[0]`=1; set wins over clear in the same cycle
  - Accesses outside BASE are not errors; they belong to memory
- `DEV_We` is never asserted for bridge-register or unmapped addresses

## Timing
- Reset (`rst_n`=0, async): s1, s2, s3, pend and err all clear to 0
  - `HWInt`=0 during reset; `PrErr`-visible err=0
  - `PrRD` and `DEV_We` stay combinational from inputs
- Level latency: `IRQ` rising before edge k → `HWInt` high after edge k+1; falling follows with the same 2-edge latency
- Edge latency: `IRQ` rising before edge k → pend set at edge k+2 → `HWInt` high after edge k+2; pend holds until cleared, regardless of `IRQ`
- Clear latency: write at edge k → `HWInt[i]` low after edge k; a new rising edge detected at edge k sets it again
- An `IRQ` held high through reset release looks like a rising edge: edge channels latch pend 3 edges after deassertion
- `IRQ` pulses shorter than one clock period may be missed; devices must hold ≥ 2 cycles
- Reads: zero wait states; `PrRD` is valid in the same cycle as `PrAddr`

## Test plan
- NDEV=4: write 0x00007F24 with `PrWe`=1 → `DEV_We`=4'b0100, `DEV_Addr`=2'b01; read 0x00007F30 with `DEV_RD` slice 3 = 32'hCAFE0003 → `PrRD`=32'hCAFE0003
- NDEV=4: read 0x00007F50 with `PrRe`=1 → `PrRD`=0, `DEV_We`=0, ERR reads 1 next cycle; write ERR with `PrWD`=1 → ERR reads 0
- Level channel 0: `IRQ[0]` high at cycle 10 → `HWInt[0]`=1 from cycle 12; `IRQ[0]` low at cycle 20 → `HWInt[0]`=0 from cycle 22
- Edge channel 1 (EDGE_MASK=4'b0010): 3-cycle pulse on `IRQ[1]` → `HWInt[1]` stays 1 after the pulse ends; IPEND reads 32'h2; write IPEND `PrWD`=32'h2 → `HWInt[1]`=0
- Edge channel 1: new rising edge detected in the same cycle as the IPEND clear → pend remains 1
- Assert `rst_n`=0 mid-run with pend and err set → `HWInt`=0 and ERR=0 immediately, without waiting for a clock edge; `IRQ` held high through release → edge channel sets 3 edges after release
